// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and default-slave state type.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    DS_IDLE,
    DS_ERR1,
    DS_ERR2
  } ds_state_t;

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave: answers unmapped active transfers with a
// two-cycle ERROR response.
module ahb_default_slave
  import ahb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic hready,
  input  logic xfer_req,
  output logic hreadyout,
  output logic hresp
);

  ds_state_t state;
  ds_state_t state_nxt;

  always_ff @(posedge clk) begin
    if (rst) state <= DS_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    hreadyout = 1'b1;
    hresp     = HRESP_OKAY;
    unique case (state)
      DS_IDLE: begin
        if (hready && xfer_req) state_nxt = DS_ERR1;
      end
      DS_ERR1: begin
        hreadyout = 1'b0;
        hresp     = HRESP_ERROR;
        state_nxt = DS_ERR2;
      end
      DS_ERR2: begin
        hresp = HRESP_ERROR;
        // ERR2 completes the transfer, so a new error can chain here
        if (hready && xfer_req) state_nxt = DS_ERR1;
        else                    state_nxt = DS_IDLE;
      end
      default: state_nxt = DS_IDLE;
    endcase
  end

endmodule

// File: rtl/ahb_decoder_mux.sv
// AHB-Lite address decoder and response mux with a
// built-in default slave for unmapped regions.
module ahb_decoder_mux
  import ahb_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int N_SLAVES   = 3,
  parameter int SEL_BITS   = 3,
  parameter int FIRST_CODE = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDR_W-1:0]          haddr,
  input  logic [1:0]                 htrans,
  output logic [N_SLAVES-1:0]        hsel,
  input  logic [N_SLAVES*DATA_W-1:0] hrdata_s,
  input  logic [N_SLAVES-1:0]        hreadyout_s,
  input  logic [N_SLAVES-1:0]        hresp_s,
  output logic [DATA_W-1:0]          hrdata,
  output logic                       hready,
  output logic                       hresp
);

  if (N_SLAVES < 1 ||
      FIRST_CODE + N_SLAVES > (1 << SEL_BITS)) begin : g_bad_map
    $fatal(1, "ahb_decoder_mux: region map exceeds code space");
  end

  logic [SEL_BITS-1:0] code;
  logic [N_SLAVES-1:0] hsel_dec;
  logic                mapped;
  logic                active;
  logic                xfer_req;
  logic                ds_ready;
  logic                ds_resp;
  logic                unused_addr;

  // Bit N_SLAVES marks the default slave; all-zero means NONE
  logic [N_SLAVES:0]   dp_own;

  assign code        = haddr[ADDR_W-1 -: SEL_BITS];
  assign unused_addr = ^haddr[ADDR_W-SEL_BITS-1:0];

  for (genvar i = 0; i < N_SLAVES; i++) begin : g_dec
    assign hsel_dec[i] = (code == SEL_BITS'(FIRST_CODE + i));
  end

  assign mapped   = |hsel_dec;
  assign active   = (htrans == HTRANS_NONSEQ) ||
                    (htrans == HTRANS_SEQ);
  assign xfer_req = !mapped && active;
  assign hsel     = rst ? '0 : hsel_dec;

  always_ff @(posedge clk) begin
    if (rst)         dp_own <= '0;
    else if (hready) dp_own <= {xfer_req, hsel_dec};
  end

  ahb_default_slave u_def (
    .clk       (clk),
    .rst       (rst),
    .hready    (hready),
    .xfer_req  (xfer_req),
    .hreadyout (ds_ready),
    .hresp     (ds_resp)
  );

  always_comb begin
    hready = 1'b1;
    hresp  = HRESP_OKAY;
    hrdata = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (dp_own[i]) begin
        hready = hreadyout_s[i];
        hresp  = hresp_s[i];
        hrdata = hrdata_s[i*DATA_W +: DATA_W];
      end
    end
    if (dp_own[N_SLAVES]) begin
      hready = ds_ready;
      hresp  = ds_resp;
    end
  end

endmodule

// File: tb/tb_ahb_decoder_mux.sv
// Directed bench for ahb_decoder_mux with default parameters.
module tb_ahb_decoder_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] haddr;
  logic [1:0]  htrans;
  logic [2:0]  hsel;
  logic [95:0] hrdata_s;
  logic [2:0]  hreadyout_s;
  logic [2:0]  hresp_s;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;

  int checks = 0;
  int errors = 0;

  ahb_decoder_mux dut (
    .clk         (clk),
    .rst         (rst),
    .haddr       (haddr),
    .htrans      (htrans),
    .hsel        (hsel),
    .hrdata_s    (hrdata_s),
    .hreadyout_s (hreadyout_s),
    .hresp_s     (hresp_s),
    .hrdata      (hrdata),
    .hready      (hready),
    .hresp       (hresp)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus(input logic [1:0] t, input logic [15:0] a);
    htrans = t;
    haddr  = a;
    #1;
  endtask

  logic [2:0] sweep_exp [8];

  initial begin
    sweep_exp = '{3'b000, 3'b001, 3'b010, 3'b100,
                  3'b000, 3'b000, 3'b000, 3'b000};
    rst         = 1'b1;
    haddr       = 16'h2000;
    htrans      = 2'b00;
    hrdata_s    = '0;
    hreadyout_s = 3'b111;
    hresp_s     = 3'b000;

    tick();
    chk("rst_hsel", 32'(hsel), 32'h0);
    chk("rst_hready", 32'(hready), 32'h1);
    chk("rst_hresp", 32'(hresp), 32'h0);
    chk("rst_hrdata", hrdata, 32'h0);
    rst = 1'b0;
    #1;
    chk("rel_hsel", 32'(hsel), 32'h1);

    tick();
    for (int c = 0; c < 8; c++) begin
      haddr = {3'(c), 13'h0};
      #0.5;
      chk($sformatf("sweep_%0d", c), 32'(hsel), 32'(sweep_exp[c]));
    end
    tick();
    bus(2'b00, 16'h0000);
    tick();

    // read from slave1 with one wait state
    hrdata_s[32 +: 32] = 32'hCAFE_0001;
    bus(2'b10, 16'h4010);
    chk("rd_hsel", 32'(hsel), 32'h2);
    tick();
    hreadyout_s = 3'b101;
    bus(2'b00, 16'h0000);
    chk("rd_wait", 32'(hready), 32'h0);
    tick();
    hreadyout_s = 3'b111;
    #1;
    chk("rd_ready", 32'(hready), 32'h1);
    chk("rd_data", hrdata, 32'hCAFE_0001);
    chk("rd_resp", 32'(hresp), 32'h0);
    tick();
    chk("rd_after_data", hrdata, 32'h0);

    // single error
    bus(2'b10, 16'hE000);
    chk("err_hsel", 32'(hsel), 32'h0);
    tick();
    bus(2'b00, 16'h0000);
    chk("err1", {30'h0, hready, hresp}, 32'h1);
    tick();
    chk("err2", {30'h0, hready, hresp}, 32'h3);
    tick();
    chk("err_done", {30'h0, hready, hresp}, 32'h2);

    // back-to-back errors
    bus(2'b10, 16'h0000);
    tick();
    bus(2'b11, 16'h0004);
    chk("b2b_a_err1", {30'h0, hready, hresp}, 32'h1);
    tick();
    chk("b2b_a_err2", {30'h0, hready, hresp}, 32'h3);
    tick();
    bus(2'b00, 16'h0000);
    chk("b2b_b_err1", {30'h0, hready, hresp}, 32'h1);
    tick();
    chk("b2b_b_err2", {30'h0, hready, hresp}, 32'h3);
    tick();
    chk("b2b_done", {30'h0, hready, hresp}, 32'h2);
    tick();
    chk("idle_unmapped", {30'h0, hready, hresp}, 32'h2);

    // reset during ERR1
    bus(2'b10, 16'hE000);
    tick();
    bus(2'b00, 16'h0000);
    chk("rerr_err1", {30'h0, hready, hresp}, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rerr_clean", {30'h0, hready, hresp}, 32'h2);
    tick();
    chk("rerr_idle", {30'h0, hready, hresp}, 32'h2);

    // slave2 stalls while next address targets slave0
    hrdata_s[64 +: 32] = 32'hBEEF_0002;
    hrdata_s[0 +: 32]  = 32'h0000_5555;
    bus(2'b10, 16'h6000);
    chk("hold_hsel2", 32'(hsel), 32'h4);
    tick();
    hreadyout_s = 3'b011;
    bus(2'b10, 16'h2000);
    chk("hold_s1", 32'(hready), 32'h0);
    tick();
    chk("hold_s2", 32'(hready), 32'h0);
    tick();
    chk("hold_s3", 32'(hready), 32'h0);
    tick();
    hreadyout_s = 3'b111;
    #1;
    chk("hold_rel_ready", 32'(hready), 32'h1);
    chk("hold_rel_data", hrdata, 32'hBEEF_0002);
    tick();
    hresp_s = 3'b001;
    bus(2'b00, 16'h0000);
    chk("s0_data", hrdata, 32'h0000_5555);
    chk("s0_resp", 32'(hresp), 32'h1);
    tick();
    hresp_s = 3'b000;
    #1;
    chk("s0_done", {30'h0, hready, hresp}, 32'h2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
